// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | systolic_skew_feeder                                                     |
// | Skewed A/B edge feeder for an NxN systolic MAC array with zero flush.    |
// | Optional: FEEDER_BUBBLE_CNT_EN adds a saturating bubble_cnt output.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module systolic_skew_feeder #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int KW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] a_vec,
    input  logic [N*DW-1:0] b_vec,
    output logic [N*DW-1:0] left_out,
    output logic [N*DW-1:0] up_out,
    output logic            busy,
    output logic            done
`ifdef FEEDER_BUBBLE_CNT_EN
    ,
    output logic [15:0]     bubble_cnt
`endif
);

    // Skew drain (N-1) plus array propagation (2N-1).
    localparam int c_FLUSH_LEN = 3*N - 2;
    localparam int c_FW        = $clog2(c_FLUSH_LEN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [KW-1:0]   r_k_len;
    logic [KW-1:0]   r_vec_cnt;
    logic [c_FW-1:0] r_flush_cnt;
    logic            w_accept;
    logic            w_start_acc;
    logic            w_last_vec;
    logic            w_flush_end;
    logic [N*DW-1:0] w_a_in;
    logic [N*DW-1:0] w_b_in;

    assign w_accept    = (r_state == S_STREAM) && in_valid;
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_last_vec  = w_accept && (r_vec_cnt == (r_k_len - KW'(1)));
    assign w_flush_end = (r_state == S_FLUSH) &&
                         (r_flush_cnt == c_FW'(c_FLUSH_LEN - 1));

    // Non-accepted cycles feed zeros, so bubbles and flush are harmless to the PEs.
    assign w_a_in = w_accept ? a_vec : '0;
    assign w_b_in = w_accept ? b_vec : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (k_len != '0) ? S_STREAM : S_FLUSH;
                end
            end
            S_STREAM: begin
                in_ready = 1'b1;
                if (w_last_vec) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_flush_end) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_k_len     <= '0;
            r_vec_cnt   <= '0;
            r_flush_cnt <= '0;
        end else if (w_start_acc) begin
            r_k_len     <= k_len;
            r_vec_cnt   <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_vec_cnt <= r_vec_cnt + KW'(1);
            end
            if ((r_state == S_FLUSH) && !w_flush_end) begin
                r_flush_cnt <= r_flush_cnt + c_FW'(1);
            end
        end
    end

`ifdef FEEDER_BUBBLE_CNT_EN
    logic [15:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bubble_cnt <= '0;
        end else if (w_start_acc) begin
            r_bubble_cnt <= '0;
        end else if ((r_state == S_STREAM) && !in_valid && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`endif

    // Lane i is a register chain of depth i+1 on both edges.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DW-1:0] r_a_sr [gi+1];
        logic [DW-1:0] r_b_sr [gi+1];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int k = 0; k <= gi; k++) begin
                    r_a_sr[k] <= '0;
                    r_b_sr[k] <= '0;
                end
            end else begin
                r_a_sr[0] <= w_a_in[gi*DW +: DW];
                r_b_sr[0] <= w_b_in[gi*DW +: DW];
                for (int k = 1; k <= gi; k++) begin
                    r_a_sr[k] <= r_a_sr[k-1];
                    r_b_sr[k] <= r_b_sr[k-1];
                end
            end
        end

        assign left_out[gi*DW +: DW] = r_a_sr[gi];
        assign up_out[gi*DW +: DW]   = r_b_sr[gi];
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_systolic_skew_feeder                                                  |
// | Self-checking bench: vector table, corner sequences, random jobs, MAC.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_systolic_skew_feeder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int KW = 8;
    localparam int F  = 3*N - 2;
    localparam int VW = N*DW;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic [KW-1:0] k_len    = '0;
    logic [VW-1:0] a_vec    = '0;
    logic [VW-1:0] b_vec    = '0;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic [VW-1:0] left_out;
    logic [VW-1:0] up_out;
`ifdef FEEDER_BUBBLE_CNT_EN
    logic [15:0]   bubble_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;
    bit mon_en  = 1'b0;
    bit pe_clr  = 1'b0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.N(N), .DW(DW), .KW(KW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .k_len      (k_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_vec      (a_vec),
        .b_vec      (b_vec),
        .left_out   (left_out),
        .up_out     (up_out),
        .busy       (busy),
        .done       (done)
`ifdef FEEDER_BUBBLE_CNT_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: job timeline in counts, plus the history of values pushed into lanes.
    bit            m_active, m_done, m_acc;
    int            m_left, m_tail, m_bub;
    logic [VW-1:0] m_ha [N];
    logic [VW-1:0] m_hb [N];
    logic [VW-1:0] e_left, e_up;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 1'b0; m_done = 1'b0; m_left = 0; m_tail = 0; m_bub = 0;
            for (int i = 0; i < N; i++) begin m_ha[i] = '0; m_hb[i] = '0; end
        end else begin
            m_acc = m_active && (m_left > 0) && in_valid;
            if (m_active && (m_left > 0) && !in_valid && (m_bub < 65535)) m_bub++;
            for (int i = N-1; i > 0; i--) begin m_ha[i] = m_ha[i-1]; m_hb[i] = m_hb[i-1]; end
            m_ha[0] = m_acc ? a_vec : '0;
            m_hb[0] = m_acc ? b_vec : '0;
            if (m_done) m_done = 1'b0;
            else if (!m_active) begin
                if (start) begin m_active = 1'b1; m_left = int'(k_len); m_tail = F; m_bub = 0; end
            end else if (m_left > 0) begin
                if (in_valid) m_left--;
            end else begin
                m_tail--;
                if (m_tail == 0) begin m_active = 1'b0; m_done = 1'b1; end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < N; i++) begin
                e_left[i*DW +: DW] = m_ha[i][i*DW +: DW];
                e_up[i*DW +: DW]   = m_hb[i][i*DW +: DW];
            end
            check("mon.left_out", 64'(left_out), 64'(e_left));
            check("mon.up_out",   64'(up_out),   64'(e_up));
            check("mon.in_ready", 64'(in_ready), 64'(m_active && (m_left > 0)));
            check("mon.busy",     64'(busy),     64'(m_active || m_done));
            check("mon.done",     64'(done),     64'(m_done));
`ifdef FEEDER_BUBBLE_CNT_EN
            check("mon.bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
`endif
        end
    end

    // Behavioural 4x4 MAC array driven by the feeder edges.
    logic [DW-1:0] pl [N][N];
    logic [DW-1:0] pu [N][N];
    logic [DW-1:0] pa [N][N];
    logic [DW-1:0] pe_l, pe_u;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) pe_l = left_out[i*DW +: DW]; else pe_l = pl[i][j-1];
                if (i == 0) pe_u = up_out[j*DW +: DW];   else pe_u = pu[i-1][j];
                if (pe_clr) begin
                    pl[i][j] <= '0; pu[i][j] <= '0; pa[i][j] <= '0;
                end else begin
                    pl[i][j] <= pe_l; pu[i][j] <= pe_u; pa[i][j] <= pa[i][j] + pe_l * pe_u;
                end
            end
        end
    end

    typedef struct {
        bit            start;
        logic [KW-1:0] k;
        bit            valid;
        logic [VW-1:0] a, b, e_left, e_up;
        bit            e_ready, e_busy, e_done;
    } row_t;

    row_t tbl [13];

    task automatic run_table();
        for (int r = 0; r < 13; r++) begin
            start = tbl[r].start; k_len = tbl[r].k; in_valid = tbl[r].valid;
            a_vec = tbl[r].a;     b_vec = tbl[r].b;
            @(negedge clk);
            check($sformatf("tbl[%0d].left", r),  64'(left_out), 64'(tbl[r].e_left));
            check($sformatf("tbl[%0d].up", r),    64'(up_out),   64'(tbl[r].e_up));
            check($sformatf("tbl[%0d].ready", r), 64'(in_ready), 64'(tbl[r].e_ready));
            check($sformatf("tbl[%0d].busy", r),  64'(busy),     64'(tbl[r].e_busy));
            check($sformatf("tbl[%0d].done", r),  64'(done),     64'(tbl[r].e_done));
        end
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic do_start(input int k);
        start = 1'b1; k_len = KW'(k); in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; k_len = KW'($urandom);
    endtask

    task automatic feed();
        in_valid = 1'b1; a_vec = VW'($urandom); b_vec = VW'($urandom);
        @(negedge clk);
        in_valid = 1'b0; a_vec = VW'($urandom); b_vec = VW'($urandom);
    endtask

    task automatic wait_done(input int budget, inout int cur);
        while (!done && budget > 0) begin @(negedge clk); cur++; budget--; end
        check("wait_done", 64'(done), 64'd1);
    endtask

    int ma [N][N];
    int mb [N][N];

    initial begin
        int cur;
        int k;
        int s;
        bit seen_ready;

        tbl[0]  = '{1'b1, 8'd1, 1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 8'd0, 1'b1, 32'h04030201, 32'h08070605, 32'h00000001, 32'h00000005, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 8'd0, 1'b0, '0, '0, 32'h00000200, 32'h00000600, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 8'd0, 1'b0, '0, '0, 32'h00030000, 32'h00070000, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 8'd0, 1'b0, '0, '0, 32'h04000000, 32'h08000000, 1'b0, 1'b1, 1'b0};
        for (int r = 5; r <= 10; r++) tbl[r] = '{1'b0, 8'd0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 8'd0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 8'd0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0};

        // Reset held with random inputs.
        for (int c = 0; c < 4; c++) begin
            start = 1'($urandom); in_valid = 1'($urandom); k_len = KW'($urandom);
            a_vec = VW'($urandom); b_vec = VW'($urandom);
            @(negedge clk);
            check("rst.left",  64'(left_out), 64'd0);
            check("rst.up",    64'(up_out),   64'd0);
            check("rst.ready", 64'(in_ready), 64'd0);
            check("rst.busy",  64'(busy),     64'd0);
            check("rst.done",  64'(done),     64'd0);
        end
        start = 1'b0; in_valid = 1'b0;
        reset = 1'b1; mon_en = 1'b1;
        repeat (3) @(negedge clk);

        run_table();

        // Two bubbles between vectors 2 and 3.
        do_start(3); cur = 1;
        feed(); feed();
        in_valid = 1'b0; @(negedge clk); @(negedge clk);
        feed(); cur = 6;
        wait_done(40, cur);
        check("bubble.done_cycle", 64'(cur), 64'd16);
`ifdef FEEDER_BUBBLE_CNT_EN
        check("bubble.cnt", 64'(bubble_cnt), 64'd2);
`endif
        @(negedge clk);

        // Empty job: straight to flush.
        do_start(0); cur = 1; seen_ready = in_ready;
        while (!done && cur < 40) begin @(negedge clk); cur++; seen_ready |= in_ready; end
        check("k0.done_cycle", 64'(cur), 64'd11);
        check("k0.no_ready",   64'(seen_ready), 64'd0);
        @(negedge clk);

        // Reset in the middle of streaming.
        do_start(4); feed(); feed();
        #2 reset = 1'b0;
        #1;
        check("mrst.left",  64'(left_out), 64'd0);
        check("mrst.up",    64'(up_out),   64'd0);
        check("mrst.ready", 64'(in_ready), 64'd0);
        check("mrst.busy",  64'(busy),     64'd0);
        check("mrst.done",  64'(done),     64'd0);
        repeat (3) begin start = 1'($urandom); in_valid = 1'b1; @(negedge clk); end
        start = 1'b0; in_valid = 1'b0;
        #1 reset = 1'b1;
        @(negedge clk);
        run_table();

        // Feeder into the MAC array, random 4x4 operands.
        pe_clr = 1'b1; @(negedge clk); pe_clr = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin ma[i][j] = $urandom_range(0, 255); mb[i][j] = $urandom_range(0, 255); end
        do_start(N);
        for (int kk = 0; kk < N; kk++) begin
            for (int i = 0; i < N; i++) begin
                a_vec[i*DW +: DW] = DW'(ma[i][kk]);
                b_vec[i*DW +: DW] = DW'(mb[kk][i]);
            end
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0; cur = 0;
        wait_done(40, cur);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int kk = 0; kk < N; kk++) s += ma[i][kk] * mb[kk][j];
                check($sformatf("mac[%0d][%0d]", i, j), 64'(pa[i][j]), 64'(s & 255));
            end
        @(negedge clk);

        // Random jobs, back-to-back, with bubbles and ignored start/k_len noise.
        for (int jb = 0; jb < 6; jb++) begin
            k = (jb == 2) ? 0 : $urandom_range(1, 12);
            do_start(k); cur = 0;
            while (!done && cur < 200) begin
                in_valid = ($urandom_range(0, 9) < 7);
                a_vec = VW'($urandom); b_vec = VW'($urandom);
                start = 1'($urandom); k_len = KW'($urandom);
                @(negedge clk); cur++;
            end
            check("job.done_seen", 64'(done), 64'd1);
            start = 1'b0; in_valid = 1'b0;
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
